// File: rtl/mem_stage_sbuf_if.sv
// Data-bus port of the memory stage: single-outstanding req/ack transfers.
interface mem_stage_sbuf_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                    busReq;
   logic                    busWe;
   logic [ADDR_WIDTH-1:0]   busAddr;
   logic [DATA_WIDTH/8-1:0] busBe;
   logic [DATA_WIDTH-1:0]   busWrData;
   logic                    busAck;
   logic [DATA_WIDTH-1:0]   busRdData;

   modport master (
      output busReq, busWe, busAddr, busBe, busWrData,
      input  busAck, busRdData
   );

   modport slave (
      input  busReq, busWe, busAddr, busBe, busWrData,
      output busAck, busRdData
   );
endinterface

// File: rtl/mem_stage_sbuf.sv
// Pipeline memory stage with a DEPTH-entry store buffer, store-to-load forwarding,
// load-priority req/ack bus FSM and misalignment reporting.
module mem_stage_sbuf #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_isValid,
   input  logic [DATA_WIDTH-1:0] i_dataR,
   input  logic [DATA_WIDTH-1:0] i_dataB,
   input  logic                  i_memWrEnable,
   input  logic                  i_memRdEnable,
   input  logic [1:0]            i_memAccess,
   input  logic                  i_memUnsigned,
   input  logic                  i_regWrDataSel,
   output logic [DATA_WIDTH-1:0] o_regWrData,
   output logic                  o_hazard,
   output logic                  o_alignError,
   output logic                  o_sbEmpty,
   output logic                  o_evMemWrite,
   output logic                  o_evMemRead,
   mem_stage_sbuf_if.master      io_bus
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int OW = $clog2(NB);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [NB-1:0]         be;
      logic [DATA_WIDTH-1:0] data;
   } sb_entry_t;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

   sb_entry_t             r_sb [DEPTH];
   logic [DEPTH-1:0]      r_valid;
   logic [PW-1:0]         r_head, r_tail;
   logic [PW:0]           r_count;
   state_t                r_state;
   logic                  r_busReq, r_busWe;
   logic [ADDR_WIDTH-1:0] r_busAddr;
   logic [NB-1:0]         r_busBe;
   logic [DATA_WIDTH-1:0] r_busWrData;

   logic [ADDR_WIDTH-1:0] w_addr, w_wordAddr;
   logic [OW-1:0]         w_off;
   int                    w_nbytes;
   logic                  w_misal, w_st, w_ld, w_enq, w_pop, w_full;
   logic [NB-1:0]         w_be;
   logic [DATA_WIDTH-1:0] w_wrData, w_src, w_lane, w_ldData;
   logic [DEPTH-1:0]      w_match;
   logic [PW-1:0]         w_sel, w_idx;
   logic                  w_anyMatch, w_fwd, w_ldBus, w_ldDone;

   assign w_addr     = i_dataR[ADDR_WIDTH-1:0];
   assign w_off      = w_addr[OW-1:0];
   assign w_wordAddr = {w_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
   assign w_nbytes   = 1 << i_memAccess;

   // A dword access only exists on a 64-bit datapath; elsewhere it is rejected.
   always_comb begin
      w_misal = 1'b0;
      case (i_memAccess)
         2'd1:    w_misal = w_addr[0];
         2'd2:    w_misal = |w_addr[1:0];
         2'd3:    w_misal = (DATA_WIDTH != 64) || (|w_addr[2:0]);
         default: w_misal = 1'b0;
      endcase
   end

   assign o_alignError = i_isValid & (i_memWrEnable | i_memRdEnable) & w_misal;
   assign w_st = i_isValid & i_memWrEnable & ~w_misal;
   assign w_ld = i_isValid & i_memRdEnable & ~i_memWrEnable & ~w_misal;

   always_comb begin
      w_be     = '0;
      w_wrData = '0;
      for (int i = 0; i < NB; i++) begin
         w_be[i]           = (i >= int'(w_off)) && (i < int'(w_off) + w_nbytes);
         w_wrData[i*8 +: 8] = i_dataB[(i % w_nbytes)*8 +: 8];
      end
   end

   // Scan oldest to youngest so the youngest matching entry is the one kept.
   always_comb begin
      w_sel = r_head;
      w_idx = '0;
      for (int k = 0; k < DEPTH; k++)
         w_match[k] = r_valid[k] && (r_sb[k].addr == w_wordAddr);
      for (int k = DEPTH - 1; k >= 0; k--) begin
         w_idx = r_tail - PW'(1) - PW'(k);
         if (w_match[w_idx]) w_sel = w_idx;
      end
   end

   assign w_anyMatch = |w_match;
   assign w_fwd      = w_ld & w_anyMatch & ((r_sb[w_sel].be & w_be) == w_be);
   assign w_ldBus    = w_ld & ~w_anyMatch;
   assign w_ldDone   = w_ld & (r_state == S_READ) & io_bus.busAck;
   assign w_full     = (r_count == (PW+1)'(DEPTH));
   assign w_enq      = w_st & ~w_full;
   assign w_pop      = (r_state == S_WRITE) & io_bus.busAck;

   assign w_src  = w_fwd ? r_sb[w_sel].data : io_bus.busRdData;
   assign w_lane = w_src >> {w_off, 3'b000};

   always_comb begin
      w_ldData = w_lane;
      for (int b = 0; b < DATA_WIDTH; b++)
         if (b >= w_nbytes * 8)
            w_ldData[b] = ~i_memUnsigned & w_lane[w_nbytes*8 - 1];
   end

   assign o_regWrData  = (i_regWrDataSel & ~o_alignError) ? w_ldData : i_dataR;
   assign o_hazard     = (w_st & w_full) | (w_ld & ~w_fwd & ~w_ldDone);
   assign o_evMemWrite = w_enq;
   assign o_evMemRead  = w_fwd | w_ldDone;
   assign o_sbEmpty    = (r_count == '0) & (r_state != S_WRITE);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_valid     <= '0;
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_state     <= S_IDLE;
         r_busReq    <= 1'b0;
         r_busWe     <= 1'b0;
         r_busAddr   <= '0;
         r_busBe     <= '0;
         r_busWrData <= '0;
      end else begin
         if (w_enq) begin
            r_sb[r_tail]    <= '{addr: w_wordAddr, be: w_be, data: w_wrData};
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + PW'(1);
         end
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PW'(1);
         end
         r_count <= r_count + (PW+1)'(w_enq) - (PW+1)'(w_pop);

         case (r_state)
            S_IDLE: begin
               if (w_ldBus) begin
                  r_state     <= S_READ;
                  r_busReq    <= 1'b1;
                  r_busWe     <= 1'b0;
                  r_busAddr   <= w_wordAddr;
                  r_busBe     <= w_be;
                  r_busWrData <= '0;
               end else if (r_count != '0) begin
                  r_state     <= S_WRITE;
                  r_busReq    <= 1'b1;
                  r_busWe     <= 1'b1;
                  r_busAddr   <= r_sb[r_head].addr;
                  r_busBe     <= r_sb[r_head].be;
                  r_busWrData <= r_sb[r_head].data;
               end
            end
            S_READ, S_WRITE: begin
               if (io_bus.busAck) begin
                  r_state  <= S_IDLE;
                  r_busReq <= 1'b0;
                  r_busWe  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_bus.busReq    = r_busReq;
   assign io_bus.busWe     = r_busWe;
   assign io_bus.busAddr   = r_busAddr;
   assign io_bus.busBe     = r_busBe;
   assign io_bus.busWrData = r_busWrData;
endmodule

// File: doc/mem_stage_sbuf.md
Name: mem_stage_sbuf

Overview:
Parametrised successor to the pipeline memory stage. It sits between EX/MEM and MEM/WB and adds a DEPTH-entry store buffer, so committed stores retire without stalling. It forwards store data to younger loads, runs a single-outstanding req/ack data-bus FSM with load priority, and reports misaligned accesses instead of issuing them. It also drives one-shot performance events.

Parameters:
DATA_WIDTH  32  data/register width (32 or 64)
ADDR_WIDTH  32  data address width
DEPTH       4   store buffer entries (power of two, 2..16)

Ports:
i_clock          in   1             clock
i_reset          in   1             synchronous active-high reset
i_isValid        in   1             stage holds a valid instruction
i_dataR          in   DATA_WIDTH    ALU result / effective address
i_dataB          in   DATA_WIDTH    store data
i_memWrEnable    in   1             store
i_memRdEnable    in   1             load
i_memAccess      in   2             0 byte, 1 half, 2 word, 3 dword (DATA_WIDTH=64 only)
i_memUnsigned    in   1             zero-extend load
i_regWrDataSel   in   1             0 = i_dataR, 1 = load data
o_regWrData      out  DATA_WIDTH    writeback data
o_hazard         out  1             stall request to pipeline
o_alignError     out  1             misaligned access (one cycle per instruction)
o_sbEmpty        out  1             store buffer empty (fence support)
o_evMemWrite     out  1             store accepted event
o_evMemRead      out  1             load completed event
o_busReq         out  1             bus request
o_busWe          out  1             1 write, 0 read
o_busAddr        out  ADDR_WIDTH    word-aligned address (low log2(DATA_WIDTH/8) bits 0)
o_busBe          out  DATA_WIDTH/8  byte enables
o_busWrData      out  DATA_WIDTH    lane-aligned write data
i_busAck         in   1             transfer done; i_busRdData valid this cycle
i_busRdData      in   DATA_WIDTH    read data

Behaviour:
- Reset (sync, i_reset=1 at posedge): buffer emptied, head/tail/count=0, FSM=IDLE. All outputs except o_regWrData are 0 and o_sbEmpty=1. Reset mid-transaction drops o_busReq next cycle and discards buffered stores.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0. If misaligned and valid, o_alignError=1 combinationally. There is no enqueue, no bus access and no stall, and o_regWrData=i_dataR.
- Store (valid, aligned): entry = {word addr, BE from size/offset, data replicated to lanes}.
  - count<DEPTH: enqueued at the clock edge, o_hazard=0, o_evMemWrite=1 for that cycle only.
  - count==DEPTH: o_hazard=1 until a slot is free (registered count; no same-cycle enqueue+full bypass). o_evMemWrite only in the accept cycle.
- Load forwarding: compare the load word address against all valid entries.
  - If the youngest matching entry's BE covers every load byte: data is taken from it with zero latency, o_hazard=0, no bus access.
  - If there is a match without full coverage: o_hazard=1 until no matching entry remains (drained), then a normal bus load.
- Load via bus: the load takes priority over queued stores, but never preempts a store already in WRITE. It is issued from IDLE and o_hazard=1 until the i_busAck cycle. In that cycle, the extracted lane, sign- or zero-extended, appears on o_regWrData, o_hazard=0 and o_evMemRead=1 (once per load).
- FSM: IDLE -> READ (pending load) else IDLE -> WRITE (count>0). READ/WRITE -> IDLE on i_busAck. The minimum gap is one IDLE cycle between transactions.
  - While in READ/WRITE, o_busReq=1 and the address, BE and data are held stable.
  - A WRITE ack pops the head.
- o_sbEmpty = (count==0) & FSM!=WRITE.
- o_regWrData = i_regWrDataSel ? loadData : i_dataR. Pointers wrap modulo DEPTH.
- i_isValid=0: no events, no enqueue, no new load. Queued stores keep draining.

Test Plan:
1. Reset, DATA_WIDTH=32: after i_reset=1 for 1 cycle, o_busReq=0, o_hazard=0, o_sbEmpty=1, all events 0.
2. Store word 0xDEADBEEF to 0x100, then lw 0x100 next cycle: store gives no stall and o_evMemWrite=1 one cycle. The load forwards with o_regWrData=0xDEADBEEF, o_hazard=0 and no READ issued. The bus then sees a write of 0x100 with BE=1111.
3. sb 0x80 to 0x203, then lw 0x200: partial match, so o_hazard=1 until the write is acked. A READ of 0x200 follows; with i_busRdData=0x80112233, o_regWrData=0x80112233. lb 0x203 gives 0xFFFFFF80; lbu gives 0x00000080.
4. DEPTH=4, bus ack held low, 5 consecutive stores: the first 4 are accepted (4 o_evMemWrite pulses), the 5th stalls with o_hazard=1. After the first ack it is accepted at the next edge; total o_evMemWrite pulses = 5.
5. lh to 0x101: o_alignError=1 for one cycle, o_busReq stays 0, o_hazard=0. sw to 0x102: same result, count unchanged.
6. Reset asserted while in WRITE with 3 entries queued: o_busReq=0 and o_sbEmpty=1 the next cycle; a following lw issues a READ immediately.
